rtc_timer: RTL and testbench
============================

Name: rtc_timer

Overview:
- Parametrised successor to the fixed clock counter.
- Generates its own centisecond tick from the system clock and keeps a 4-field BCD time value {HH,MM,SS,CC}, 8 bits per field.
- Three run modes: time-of-day clock, stopwatch, countdown timer. Supports pause and synchronous load.
- Output `out` feeds the existing display mux directly; `tick` and `done` feed board glue (LEDs, buzzer).

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, field CC rate. DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2.
- HOUR_MOD, 24, hour wrap modulus in clock mode. Legal range 1..100.

Ports:
- clk_50mhz  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  2  00 clock, 01 stopwatch, 10 countdown, 11 hold.
- pause  in  1  level; 1 freezes prescaler and time.
- load  in  1  single-cycle strobe; load load_val.
- load_val  in  32  BCD {HH,MM,SS,CC}.
- out  out  32  current time, BCD {HH,MM,SS,CC}.
- tick  out  1  one-cycle pulse per time update.
- rollover  out  1  one-cycle pulse on HH wrap in clock mode.
- done  out  1  level; stopwatch saturated or countdown reached zero.

Behaviour:
- Reset (rst=0, async): prescaler=0, out=0, tick=0, rollover=0, done=0.
- Prescaler runs 0..DIV-1 while pause=0 and mode!=11. It holds its value (does not clear) while paused or in mode 11.
- Update edge: the rising edge where prescaler==DIV-1, pause=0 and no load. On that edge:
  - prescaler goes to 0;
  - out takes its next value;
  - tick=1 for exactly that following cycle, so the new out and tick are visible together.
- Load priority: load > update > pause. On load:
  - out=load_val, prescaler=0, done=0, tick=0.
  - Load works while paused.
- Invalid load fields are forced to 00 per field:
  - any BCD nibble >9;
  - MM or SS tens nibble >5;
  - HH ≥ HOUR_MOD, clock mode only.
- Mode 00, clock (up-count):
  - CC 99→00 carries into SS; SS 59→00 carries into MM; MM 59→00 carries into HH.
  - HH HOUR_MOD-1→00 pulses rollover with that tick.
  - done is forced to 0.
- Mode 01, stopwatch:
  - Same carry chain, but HH counts to 99.
  - At 99:59:59.99 the next update leaves out unchanged and sets done=1. tick still pulses.
- Mode 10, countdown:
  - Borrow chain: CC 00→99 borrows from SS; SS 00→59 borrows from MM; MM 00→59 borrows from HH.
  - The update that produces 00:00:00.00 also sets done=1.
  - If out==0 at an update, out stays 0 and done=1.
- Mode 11, hold: no updates, tick=0, done held.
- done stays high until load, reset, or any change of mode.
- A mode change takes effect at the next update edge. The prescaler is not cleared.
- rollover is never asserted outside mode 00.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RTC_TIMER_ALARM_EN.
- When defined, add ports:
  - alarm_val  in  24  BCD {HH,MM,SS}
  - alarm_en  in  1
  - alarm  out  1
- alarm pulses for one cycle when all of the following hold:
  - mode==00;
  - alarm_en=1;
  - an update edge has just produced out[31:8]==alarm_val with CC==00.
- A load never triggers alarm. Reset value of alarm is 0.
- When not defined: these ports and all related logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rtc_pkg holds:
  - mode encodings MODE_CLOCK, MODE_STOPWATCH, MODE_COUNTDOWN, MODE_HOLD;
  - FIELD_W=8;
  - BCD limit constants 99 and 59.
- One sub-module, bcd_field:
  - two-digit BCD up/down counter with parameter MOD;
  - inputs en, up, load, load_val;
  - outputs value, carry/borrow out.
- rtc_timer instantiates four bcd_field instances (CC MOD 100, SS 60, MM 60, HH HOUR_MOD or 100) plus the prescaler and the done/mode logic.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset then mode=00, run 10 cycles → tick exactly once on cycle 10; out=00:00:00.01.
- Clock mode: load 23:59:59.99, one tick → out=00:00:00.00, rollover=1 for 1 cycle. Repeat with HOUR_MOD=12, load 11:59:59.99 → 00:00:00.00.
- Countdown: load 00:00:01.00, 100 ticks → out=0, done=1 on the 100th tick. A further 50 ticks → out stays 0, done stays 1. Then load 00:00:00.05 → done=0.
- Pause: assert pause at prescaler=4 for 37 cycles → out frozen; after release, next tick arrives 6 cycles later. Load during pause with 12:34:56.78 → out updates immediately.
- Invalid load 25:6A:59.99 in mode 00 → out=00:00:59.99. Stopwatch load 99:59:59.99, one tick → out unchanged, done=1, tick pulsed.
- With RTC_TIMER_ALARM_EN: alarm_val 00:00:01, alarm_en=1, from reset → alarm pulses once, together with tick 100. With alarm_en=0 → no pulse.

Source files
------------

// File: rtl/rtc_timer_pkg.sv
// Shared definitions for the rtc_timer slice: run-mode encodings, field
// width, BCD field limits and small BCD helpers.
package rtc_pkg;

  localparam int FIELD_W = 8;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'b00,
    MODE_STOPWATCH = 2'b01,
    MODE_COUNTDOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  localparam logic [FIELD_W-1:0] BCD_LIM_99 = 8'h99;
  localparam logic [FIELD_W-1:0] BCD_LIM_59 = 8'h59;

  // Two-digit BCD to binary (0..99 for legal digits).
  function automatic logic [7:0] bcd2bin(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  // Both digits legal and tens digit within the field's limit.
  function automatic logic bcd_ok(input logic [7:0] b, input logic [3:0] tens_max);
    return (b[3:0] <= 4'd9) && (b[7:4] <= tens_max);
  endfunction

endpackage

// File: rtl/rtc_timer_bcd_field.sv
// Two-digit BCD up/down counter, modulus MOD. Carry/borrow out is
// combinational so fields chain within one update edge; nxt exposes the
// value the field will take at the coming edge.
module bcd_field
  import rtc_pkg::*;
#(
  parameter int MOD = 100
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic [FIELD_W-1:0] nxt,
  output logic               co
);

  localparam int TOP = MOD - 1;
  localparam logic [7:0] TOP_BIN = 8'(TOP);
  localparam logic [7:0] TOP_BCD = {4'(TOP / 10), 4'(TOP % 10)};

  logic [FIELD_W-1:0] r_value;
  logic [FIELD_W-1:0] w_step;
  logic               w_at_top;
  logic               w_at_zero;

  assign w_at_top  = bcd2bin(r_value) >= TOP_BIN;
  assign w_at_zero = (r_value == '0);
  assign co        = en & (up ? w_at_top : w_at_zero);
  assign nxt       = load ? load_val : (en ? w_step : r_value);
  assign value     = r_value;

  // Digit-wise increment/decrement with wrap at the field modulus.
  always_comb begin
    w_step = r_value;
    if (up) begin
      if (w_at_top)                w_step = '0;
      else if (r_value[3:0] >= 4'd9) w_step = {r_value[7:4] + 4'd1, 4'd0};
      else                         w_step = {r_value[7:4], r_value[3:0] + 4'd1};
    end else begin
      if (w_at_zero)               w_step = TOP_BCD;
      else if (r_value[3:0] == 4'd0) w_step = {r_value[7:4] - 4'd1, 4'd9};
      else                         w_step = {r_value[7:4], r_value[3:0] - 4'd1};
    end
  end

  // Field register.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) r_value <= '0;
    else      r_value <= nxt;
  end

endmodule

// File: rtl/rtc_timer.sv
// Centisecond real-time clock / stopwatch / countdown timer with BCD
// {HH,MM,SS,CC} output. Optional alarm compare is built when the macro
// RTC_TIMER_ALARM_EN is defined.
module rtc_timer
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MOD = 24
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        pause,
  input  logic        load,
  input  logic [31:0] load_val,
`ifdef RTC_TIMER_ALARM_EN
  input  logic [23:0] alarm_val,
  input  logic        alarm_en,
  output logic        alarm,
`endif
  output logic [31:0] out,
  output logic        tick,
  output logic        rollover,
  output logic        done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);
  localparam logic [7:0] HOUR_MOD_BIN = 8'(HOUR_MOD);
  localparam logic [7:0] HH_TOP_BIN   = 8'(HOUR_MOD - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick, r_roll, r_done;
  logic [1:0]    r_mode_q;

  logic w_clk, w_sw, w_cd, w_running, w_update, w_adv, w_up;
  logic w_sat, w_zero, w_sw_done, w_cd_done, w_hh_wrap;
  logic [7:0] w_ld_cc, w_ld_ss, w_ld_mm, w_ld_hh;
  logic [7:0] w_cc, w_ss, w_mm, w_hh;
  logic [7:0] w_cc_nxt, w_ss_nxt, w_mm_nxt, w_hh_nxt;
  logic w_cc_co, w_ss_co, w_mm_co, w_hh_co;
  logic w_hh_load;
  logic [7:0] w_hh_load_val;
  logic [31:0] w_out_nxt;

  assign w_clk     = (mode == MODE_CLOCK);
  assign w_sw      = (mode == MODE_STOPWATCH);
  assign w_cd      = (mode == MODE_COUNTDOWN);
  assign w_running = !pause && (mode != MODE_HOLD);
  assign w_update  = (r_presc == PRESC_TOP) && w_running && !load;
  assign w_up      = !w_cd;

  assign out       = {w_hh, w_mm, w_ss, w_cc};
  assign w_out_nxt = {w_hh_nxt, w_mm_nxt, w_ss_nxt, w_cc_nxt};
  assign w_sat     = (out == {BCD_LIM_99, BCD_LIM_59, BCD_LIM_59, BCD_LIM_99});
  assign w_zero    = (out == '0);

  // Saturated stopwatch and empty countdown still tick but do not move.
  assign w_adv     = w_update && !(w_sw && w_sat) && !(w_cd && w_zero);
  assign w_sw_done = w_update && w_sw && w_sat;
  assign w_cd_done = w_update && w_cd && (w_out_nxt == '0);

  // Illegal load fields collapse to 00; hour limit only applies to the clock.
  assign w_ld_cc = bcd_ok(load_val[7:0],   BCD_LIM_99[7:4]) ? load_val[7:0]   : '0;
  assign w_ld_ss = bcd_ok(load_val[15:8],  BCD_LIM_59[7:4]) ? load_val[15:8]  : '0;
  assign w_ld_mm = bcd_ok(load_val[23:16], BCD_LIM_59[7:4]) ? load_val[23:16] : '0;
  assign w_ld_hh = (!bcd_ok(load_val[31:24], BCD_LIM_99[7:4]) ||
                    (w_clk && (bcd2bin(load_val[31:24]) >= HOUR_MOD_BIN))) ? '0 : load_val[31:24];

  // Hours field counts to 99; clock mode wraps it early by loading 00.
  assign w_hh_wrap     = w_mm_co && w_clk && (bcd2bin(w_hh) >= HH_TOP_BIN);
  assign w_hh_load     = load || w_hh_wrap;
  assign w_hh_load_val = load ? w_ld_hh : 8'h00;

  bcd_field #(.MOD(100)) u_cc (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(w_adv), .up(w_up), .load(load),
    .load_val(w_ld_cc), .value(w_cc), .nxt(w_cc_nxt), .co(w_cc_co)
  );

  bcd_field #(.MOD(60)) u_ss (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(w_cc_co), .up(w_up), .load(load),
    .load_val(w_ld_ss), .value(w_ss), .nxt(w_ss_nxt), .co(w_ss_co)
  );

  bcd_field #(.MOD(60)) u_mm (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(w_ss_co), .up(w_up), .load(load),
    .load_val(w_ld_mm), .value(w_mm), .nxt(w_mm_nxt), .co(w_mm_co)
  );

  bcd_field #(.MOD(100)) u_hh (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(w_mm_co), .up(w_up), .load(w_hh_load),
    .load_val(w_hh_load_val), .value(w_hh), .nxt(w_hh_nxt), .co(w_hh_co)
  );

  // Prescaler: cleared by load or update, frozen while paused or holding.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst)           r_presc <= '0;
    else if (load)      r_presc <= '0;
    else if (w_update)  r_presc <= '0;
    else if (w_running) r_presc <= r_presc + PW'(1);
  end

  // Tick and rollover pulses land with the updated time value.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_tick <= 1'b0;
      r_roll <= 1'b0;
    end else begin
      r_tick <= w_update;
      r_roll <= w_clk && (w_hh_wrap || w_hh_co);
    end
  end

  // done: set by saturation/zero, cleared by load, clock mode or mode change.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_done   <= 1'b0;
      r_mode_q <= MODE_CLOCK;
    end else begin
      r_mode_q <= mode;
      if (load || w_clk)              r_done <= 1'b0;
      else if (w_sw_done || w_cd_done) r_done <= 1'b1;
      else if (mode != r_mode_q)      r_done <= 1'b0;
    end
  end

  assign tick     = r_tick;
  assign rollover = r_roll;
  assign done     = r_done;

`ifdef RTC_TIMER_ALARM_EN
  logic r_alarm;

  // Alarm fires on the clock-mode update that lands on HH:MM:SS.00.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) r_alarm <= 1'b0;
    else      r_alarm <= w_update && w_clk && alarm_en &&
                         (w_out_nxt[31:8] == alarm_val) && (w_out_nxt[7:0] == 8'h00);
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_rtc_timer.sv
// Bench for rtc_timer: two instances (HOUR_MOD 24 and 12) sharing stimulus,
// checked every cycle against a centisecond-count reference model, plus
// directed boundary checks.
module tb_rtc_timer;

  localparam int DIV    = 10;
  localparam int HOUR_S = 360000;
  localparam int MAXT   = 100 * HOUR_S - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        pause, load;
  logic [31:0] load_val;
  logic [31:0] out0, out1;
  logic        tick0, tick1, roll0, roll1, done0, done1;
`ifdef RTC_TIMER_ALARM_EN
  logic [23:0] alarm_val;
  logic        alarm_en;
  logic        alarm0, alarm1;
`endif

  int checks = 0;
  int failures = 0;

  int   m_presc;
  int   m_tot [2];
  bit   m_tick;
  bit   m_roll [2];
  bit   m_done [2];
  bit   m_alarm [2];
  logic [1:0] m_prev_mode;
  int   hmod [2] = '{24, 12};

  always #5 clk = ~clk;

  rtc_timer #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24)) dut0 (
    .clk_50mhz(clk), .rst(rst_n), .mode(mode), .pause(pause), .load(load),
    .load_val(load_val),
`ifdef RTC_TIMER_ALARM_EN
    .alarm_val(alarm_val), .alarm_en(alarm_en), .alarm(alarm0),
`endif
    .out(out0), .tick(tick0), .rollover(roll0), .done(done0)
  );

  rtc_timer #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MOD(12)) dut1 (
    .clk_50mhz(clk), .rst(rst_n), .mode(mode), .pause(pause), .load(load),
    .load_val(load_val),
`ifdef RTC_TIMER_ALARM_EN
    .alarm_val(alarm_val), .alarm_en(alarm_en), .alarm(alarm1),
`endif
    .out(out1), .tick(tick1), .rollover(roll1), .done(done1)
  );

  function automatic logic [31:0] to_bcd(input int t);
    int h, m, s, c;
    h = t / HOUR_S;
    m = (t / 6000) % 60;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int sanitize(input logic [31:0] v, input logic [1:0] md, input int hm);
    int f [4];
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = v[8*i +: 8];
      if (b[3:0] > 4'd9 || b[7:4] > 4'd9 || ((i == 1 || i == 2) && b[7:4] > 4'd5)) f[i] = 0;
      else f[i] = int'(b[7:4]) * 10 + int'(b[3:0]);
    end
    if (md == 2'b00 && f[3] >= hm) f[3] = 0;
    return ((f[3] * 60 + f[2]) * 60 + f[1]) * 100 + f[0];
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_tick = 0;
    m_prev_mode = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_tot[k] = 0; m_roll[k] = 0; m_done[k] = 0; m_alarm[k] = 0;
    end
  endtask

  // One clock edge of the reference, using the inputs present at that edge.
  task automatic model_step();
    bit upd, set;
    int t1;
    upd = (m_presc == DIV - 1) && !pause && !load && (mode != 2'b11);
    if (load) m_presc = 0;
    else if (upd) m_presc = 0;
    else if (!pause && mode != 2'b11) m_presc++;
    m_tick = upd;
    for (int k = 0; k < 2; k++) begin
      m_roll[k] = 0;
      m_alarm[k] = 0;
      set = 0;
      if (load) m_tot[k] = sanitize(load_val, mode, hmod[k]);
      else if (upd) begin
        case (mode)
          2'b00: begin
            t1 = m_tot[k] + 1;
            if (t1 % HOUR_S == 0 && t1 / HOUR_S >= hmod[k]) begin
              t1 = 0;
              m_roll[k] = 1;
            end
            m_tot[k] = t1;
`ifdef RTC_TIMER_ALARM_EN
            begin
              logic [31:0] nb;
              nb = to_bcd(t1);
              if (alarm_en && t1 % 100 == 0 && nb[31:8] == alarm_val) m_alarm[k] = 1;
            end
`endif
          end
          2'b01: if (m_tot[k] == MAXT) set = 1; else m_tot[k]++;
          2'b10: begin
            if (m_tot[k] > 0) m_tot[k]--;
            if (m_tot[k] == 0) set = 1;
          end
          default: ;
        endcase
      end
      if (load || mode == 2'b00) m_done[k] = 0;
      else if (set) m_done[k] = 1;
      else if (mode != m_prev_mode) m_done[k] = 0;
    end
    m_prev_mode = mode;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out0",  out0, to_bcd(m_tot[0]));
    chk("out1",  out1, to_bcd(m_tot[1]));
    chk("tick0", 32'(tick0), 32'(m_tick));
    chk("tick1", 32'(tick1), 32'(m_tick));
    chk("roll0", 32'(roll0), 32'(m_roll[0]));
    chk("roll1", 32'(roll1), 32'(m_roll[1]));
    chk("done0", 32'(done0), 32'(m_done[0]));
    chk("done1", 32'(done1), 32'(m_done[1]));
`ifdef RTC_TIMER_ALARM_EN
    chk("alarm0", 32'(alarm0), 32'(m_alarm[0]));
    chk("alarm1", 32'(alarm1), 32'(m_alarm[1]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      do begin
        step();
        c++;
      end while (!m_tick && c < 4 * DIV);
      chk("tick_wait", 32'(m_tick), 32'd1);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out0",  out0, 32'h0);
    chk("rst_tick0", 32'(tick0), 32'd0);
    chk("rst_roll0", 32'(roll0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_out1",  out1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    mode = 2'b00;
    pause = 1'b0;
    load = 1'b0;
    load_val = '0;
`ifdef RTC_TIMER_ALARM_EN
    alarm_val = 24'h000000;
    alarm_en = 1'b0;
`endif
    #2;
    apply_reset();

    // First tick arrives on the tenth edge.
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("first_tick", 32'(tick0), (i == 10) ? 32'd1 : 32'd0);
    end
    chk("first_out", out0, 32'h00000001);

    // Hour wrap for both hour moduli.
    do_load(32'h23595999);
    chk("ld24_out0", out0, 32'h23595999);
    chk("ld24_out1", out1, 32'h00595999);
    run_ticks(1);
    chk("wrap24_out", out0, 32'h00000000);
    chk("wrap24_roll", 32'(roll0), 32'd1);
    chk("wrap24_out1", out1, 32'h01000000);
    step();
    chk("wrap24_roll_pulse", 32'(roll0), 32'd0);
    do_load(32'h11595999);
    run_ticks(1);
    chk("wrap12_out", out1, 32'h00000000);
    chk("wrap12_roll", 32'(roll1), 32'd1);
    chk("wrap12_out0", out0, 32'h12000000);

    // Countdown to zero and beyond.
    mode = 2'b10;
    do_load(32'h00000100);
    run_ticks(99);
    chk("cd99_out", out0, 32'h00000001);
    chk("cd99_done", 32'(done0), 32'd0);
    run_ticks(1);
    chk("cd100_out", out0, 32'h00000000);
    chk("cd100_done", 32'(done0), 32'd1);
    chk("cd100_tick", 32'(tick0), 32'd1);
    run_ticks(50);
    chk("cd150_out", out0, 32'h00000000);
    chk("cd150_done", 32'(done0), 32'd1);
    do_load(32'h00000005);
    chk("cd_reload_done", 32'(done0), 32'd0);

    // Pause at prescaler 4 for 37 cycles.
    mode = 2'b00;
    do_load(32'h00000000);
    repeat (4) step();
    pause = 1'b1;
    repeat (37) step();
    chk("pause_frozen", out0, 32'h00000000);
    pause = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("pause_resume_tick", 32'(tick0), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("pause_resume_out", out0, 32'h00000001);
    pause = 1'b1;
    repeat (3) step();
    do_load(32'h12345678);
    chk("pause_load0", out0, 32'h12345678);
    chk("pause_load1", out1, 32'h00345678);
    pause = 1'b0;

    // Invalid fields and stopwatch saturation.
    do_load(32'h256A5999);
    chk("bad_load0", out0, 32'h00005999);
    chk("bad_load1", out1, 32'h00005999);
    mode = 2'b01;
    do_load(32'h99595999);
    run_ticks(1);
    chk("sat_out", out0, 32'h99595999);
    chk("sat_done", 32'(done0), 32'd1);
    chk("sat_tick", 32'(tick0), 32'd1);

    // Randomised run against the reference.
    mode = 2'b10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 7) == 0);
`ifdef RTC_TIMER_ALARM_EN
      alarm_en = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 29) == 0) begin
        load = 1'b1;
        case ($urandom_range(0, 5))
          0: load_val = $urandom;
          1: load_val = 32'h23595990;
          2: load_val = 32'h11595995;
          3: load_val = 32'h99595990;
          4: load_val = 32'h00000105;
          default: load_val = 32'h00005998;
        endcase
      end
      step();
      load = 1'b0;
    end
    pause = 1'b0;

`ifdef RTC_TIMER_ALARM_EN
    begin
      int na;
      mode = 2'b00;
      alarm_val = 24'h000001;
      alarm_en = 1'b1;
      apply_reset();
      na = 0;
      for (int i = 1; i <= 1000; i++) begin
        step();
        if (alarm0) na++;
      end
      chk("alarm_at_t100", 32'(alarm0), 32'd1);
      chk("alarm_with_tick", 32'(tick0), 32'd1);
      chk("alarm_count", na, 32'd1);
      alarm_en = 1'b0;
      apply_reset();
      na = 0;
      for (int i = 1; i <= 1000; i++) begin
        step();
        if (alarm0) na++;
      end
      chk("alarm_disabled", na, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
